// File: rtl/mem_port_arbiter.sv
// Registered N-client line arbiter in front of the cacheline adaptor; grant is locked for a whole transaction.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed lowest-index priority.
module mem_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             cl_read,
    input  logic [NUM_PORTS-1:0]             cl_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cl_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  cl_wdata,
    output logic [LINE_WIDTH-1:0]            cl_rdata,
    output logic [NUM_PORTS-1:0]             cl_resp,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp
);

    localparam int IDX_WIDTH = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;

    logic [NUM_PORTS-1:0]    req;
    logic                    req_any;
    logic [IDX_WIDTH-1:0]    sel;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LINE_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PORTS - 1);
    logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
    int unsigned             idx;
`endif

    assign req     = cl_read | cl_write;
    assign req_any = |req;

    always_comb begin
        sel = '0;
`ifdef ARB_ROUND_ROBIN_EN
        idx = 0;
        // Walk downward so the last hit is the first requester at or above the pointer.
        for (int unsigned k = NUM_PORTS; k > 0; k--) begin
            idx = (32'(ptr_q) + k - 1) % NUM_PORTS;
            if (req[IDX_WIDTH'(idx)]) begin
                sel = IDX_WIDTH'(idx);
            end
        end
`else
        for (int unsigned k = NUM_PORTS; k > 0; k--) begin
            if (req[IDX_WIDTH'(k - 1)]) begin
                sel = IDX_WIDTH'(k - 1);
            end
        end
`endif
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (sel == IDX_WIDTH'(i)) begin
                sel_addr  = cl_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = cl_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
        sel_write = cl_write[sel];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = BUSY;
                    grant_d = sel;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // A simultaneous write takes precedence so the writeback precedes the refill.
                    wr_d    = sel_write;
                    rd_d    = ~sel_write;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (sel == LAST_IDX) ? '0 : sel + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = GAP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        cl_resp = '0;
        if (state_q == BUSY && mem_resp) begin
            cl_resp[grant_q] = 1'b1;
        end
    end

    assign cl_rdata    = mem_rdata;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

endmodule
